mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbiter and sequencer for the single shared main-memory port of the pipelined 16-bit CPU.
- Two requesters share the port: the instruction-side cache-fill logic (fetch stage) and the data-side cache-fill/write-through logic (memory stage).
- Performs 8-word line fills over the pipelined multi-cycle memory and single-word data writes.
- Alternates grants round-robin and never preempts a transaction once it has started.

Parameters:
- WORDS_PER_LINE, 8: words per cache line. Must be a power of 2. Line = 2*WORDS_PER_LINE bytes.
- MEM_LATENCY, 4: cycles from an issued read to its mem_rvalid. Informational only; the arbiter counts returns and never counts cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-side line-fill request, level
- i_addr  in  16  I-side miss byte address
- i_data_valid  out  1  I-side fill word valid
- i_data  out  16  I-side fill word
- i_word_idx  out  3  word index within line of i_data
- i_done  out  1  I-side transaction complete, 1-cycle pulse
- d_req  in  1  D-side request, level
- d_we  in  1  D-side: 1 = single-word write, 0 = line fill
- d_addr  in  16  D-side byte address
- d_wdata  in  16  D-side write data
- d_data_valid  out  1  D-side fill word valid
- d_data  out  16  D-side fill word
- d_word_idx  out  3  word index within line of d_data
- d_done  out  1  D-side transaction complete, 1-cycle pulse
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write, 1 = write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid
- busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, FILL_I, FILL_D, WRITE_D, DONE.
- Outputs are decoded from state and registers only (Moore), except data_valid, data and word_idx, which are qualified passthroughs of the mem_r* inputs.
- Reset, synchronous: state=IDLE, issue_cnt=0, ret_cnt=0, base=0, last_grant=I (so D wins the first tie), owner=I. All outputs 0.
- Reset mid-transaction aborts it immediately. No done pulse is produced.
- Requests are sampled only in IDLE.
- Grant rule from IDLE:
  - only one req high: that requester wins.
  - both high: the requester that is not last_grant wins.
  - last_grant and owner update on the grant edge.
- Transitions out of IDLE on grant:
  - I wins -> FILL_I.
  - D wins with d_we=0 -> FILL_D.
  - D wins with d_we=1 -> WRITE_D.
  - base latched on the same edge as {addr[15:4], 4'b0}. For WORDS_PER_LINE=8 the offset field is addr[3:0].
- FILL_x:
  - issue phase: while issue_cnt < WORDS_PER_LINE, drive mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, then increment issue_cnt. This issues one word per cycle starting in the first FILL cycle.
  - after issue phase: mem_en=0.
  - each mem_rvalid: x_data_valid=1, x_data=mem_rdata, x_word_idx=ret_cnt, then increment ret_cnt.
  - the WORDS_PER_LINE-th return moves the FSM to DONE.
- WRITE_D lasts exactly 1 cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata. Next state DONE.
- DONE lasts 1 cycle:
  - x_done=1 for the owner.
  - issue_cnt and ret_cnt cleared.
  - next state IDLE.
- Requester handshake:
  - hold req, we, addr and wdata stable from assertion through done.
  - deassert req on the clock edge where done=1, so IDLE never sees a stale request.
  - re-asserting in the IDLE cycle is permitted.
- mem_rvalid in IDLE, WRITE_D or DONE is ignored: no data_valid, no counter change.
- Non-owner data_valid is always 0.
- mem_wdata = 0 when not writing.
- Latency with L = MEM_LATENCY, request seen in IDLE at cycle 0:
  - fill: words issued cycles 1..8, returned cycles 1+L..8+L, done at cycle 9+L, IDLE at cycle 10+L.
  - write: WRITE_D at cycle 1, done at cycle 2.
- Memory stalls or gaps in mem_rvalid extend FILL with no error. No timeout.
- Counter widths: issue_cnt and ret_cnt are log2(WORDS_PER_LINE)+1 bits, so they do not wrap before reaching the terminal count.
- Simultaneous events:
  - a request arriving while busy waits. It is served by the round-robin rule on the next IDLE.
  - rst has priority over all events.

Test Plan:
- I fill alone, i_addr=0x1236, L=4:
  - mem_addr = 0x1230, 0x1232, ..., 0x123E on cycles 1..8.
  - memory returns 0xA000+k: i_data_valid on cycles 5..12 with i_word_idx 0..7 and data 0xA000..0xA007.
  - i_done on cycle 13, busy low on cycle 14.
- i_req and d_req (d_we=0, d_addr=0x0040) rise together right after reset:
  - D fill of 0x0040..0x004E completes first.
  - I fill starts in the cycle after the D-side IDLE cycle.
  - d_data_valid never asserts during the I fill.
- D write, d_addr=0x0102, d_wdata=0xBEEF:
  - one cycle with mem_en=1, mem_wr=1, mem_addr=0x0102, mem_wdata=0xBEEF.
  - d_done on the next cycle.
  - i_done stays 0 throughout.
- Fairness: i_req held high while D issues two back-to-back writes:
  - grant order is D, I, D.
  - I is never starved behind the second write.
- Reset mid-fill: assert rst on cycle 6 of an I fill:
  - next cycle state=IDLE, all outputs 0, no i_done.
  - late mem_rvalid pulses produce no i_data_valid.
- Stalled memory: during a D fill, insert 3 idle cycles before the 5th mem_rvalid:
  - ret_cnt resumes correctly.
  - d_done arrives exactly 1 cycle after the 8th return.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the CPU's single main-memory port: round-robin between
// I-side line fills and D-side fills/writes, never preempting a started transaction.
module mem_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int MEM_LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_data_valid,
  output logic [15:0] i_data,
  output logic [2:0]  i_word_idx,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_data_valid,
  output logic [15:0] d_data,
  output logic [2:0]  d_word_idx,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE) + 1;
  localparam logic [15:0]      OFFSET_MASK = 16'(2 * WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LINE_WORDS  = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Memory latency only describes the attached memory; returns are counted, never timed.
  if (MEM_LATENCY < 1) begin : g_latency_unused
  end

  typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, WRITE_D, DONE} state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} side_t;

  state_t           state;
  state_t           next_state;
  side_t            last_grant;
  side_t            owner;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [15:0]      base;
  logic             grant_i;
  logic             grant_d;
  logic             filling;
  logic             issuing;

  // D wins a tie only when I was served last, so the two sides alternate.
  assign grant_d = d_req && (!i_req || last_grant == REQ_I);
  assign grant_i = i_req && !grant_d;
  assign filling = (state == FILL_I) || (state == FILL_D);
  assign issuing = filling && (issue_cnt < LINE_WORDS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_i)      next_state = FILL_I;
        else if (grant_d) next_state = d_we ? WRITE_D : FILL_D;
      end
      FILL_I, FILL_D: begin
        if (mem_rvalid && ret_cnt == LAST_WORD) next_state = DONE;
      end
      WRITE_D: next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      base       <= '0;
      last_grant <= REQ_I;
      owner      <= REQ_I;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            last_grant <= grant_d ? REQ_D : REQ_I;
            owner      <= grant_d ? REQ_D : REQ_I;
            base       <= (grant_d ? d_addr : i_addr) & ~OFFSET_MASK;
          end
        end
        FILL_I, FILL_D: begin
          if (issuing)    issue_cnt <= issue_cnt + CNT_ONE;
          if (mem_rvalid) ret_cnt   <= ret_cnt + CNT_ONE;
        end
        DONE: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Return data is passed straight through, gated to the owning side while filling.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = (state != IDLE);
    i_done       = 1'b0;
    d_done       = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_word_idx   = '0;
    d_data_valid = 1'b0;
    d_data       = '0;
    d_word_idx   = '0;
    case (state)
      FILL_I, FILL_D: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = base + 16'({issue_cnt, 1'b0});
        end
      end
      WRITE_D: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      DONE: begin
        i_done = (owner == REQ_I);
        d_done = (owner == REQ_D);
      end
      default: ;
    endcase
    if (state == FILL_I && mem_rvalid) begin
      i_data_valid = 1'b1;
      i_data       = mem_rdata;
      i_word_idx   = 3'(ret_cnt);
    end
    if (state == FILL_D && mem_rvalid) begin
      d_data_valid = 1'b1;
      d_data       = mem_rdata;
      d_word_idx   = 3'(ret_cnt);
    end
  end

endmodule
